// File: rtl/ex_stage.sv
// ARVI execute stage: combinational ALU plus an optional iterative RV32M unit.
// Define ARVI_MULDIV_EN to build the multiply/divide unit; otherwise M ops are flagged illegal.
module ex_stage #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_alusrc,
  input  logic [3:0]      i_alu_op,
  input  logic            i_hold,
  input  logic            i_flush,
  input  logic            i_mc_memtoreg,
  input  logic            i_mc_regwrite,
  input  logic            i_mc_pcplus4,
  input  logic            i_mc_memread,
  input  logic            i_mc_memwrite,
  input  logic            i_mc_ex_inst_illegal,
  output logic [XLEN-1:0] o_alu_res,
  output logic            o_z,
  output logic [XLEN-1:0] o_pc_jump,
  output logic [XLEN-1:0] o_wr_data,
  output logic            o_stall,
  output logic            o_ex_inst_illegal,
  output logic            o_mc_memtoreg,
  output logic            o_mc_regwrite,
  output logic            o_mc_pcplus4,
  output logic            o_mc_memread,
  output logic            o_mc_memwrite,
  output logic            o_mc_ex_inst_illegal
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_alu;
  logic [CW-1:0]   w_shamt;
  logic            w_m_op;

  assign w_b     = i_alusrc ? i_imm : i_rs2;
  assign w_shamt = w_b[CW-1:0];
  assign w_m_op  = (i_inst[6:0] == 7'b0110011) && (i_inst[31:25] == 7'b0000001);

  always_comb begin
    w_alu = '0;
    case (i_alu_op)
      4'd0:    w_alu = i_rs1 + w_b;
      4'd1:    w_alu = i_rs1 - w_b;
      4'd2:    w_alu = i_rs1 << w_shamt;
      4'd3:    w_alu = {{(XLEN-1){1'b0}}, $signed(i_rs1) < $signed(w_b)};
      4'd4:    w_alu = {{(XLEN-1){1'b0}}, i_rs1 < w_b};
      4'd5:    w_alu = i_rs1 ^ w_b;
      4'd6:    w_alu = i_rs1 >> w_shamt;
      4'd7:    w_alu = XLEN'($signed(i_rs1) >>> w_shamt);
      4'd8:    w_alu = i_rs1 | w_b;
      4'd9:    w_alu = i_rs1 & w_b;
      4'd10:   w_alu = w_b;
      default: w_alu = '0;
    endcase
  end

  assign o_z           = (o_alu_res == '0);
  assign o_pc_jump     = i_pc + i_imm;
  assign o_wr_data     = i_rs2;
  assign o_mc_memtoreg = i_mc_memtoreg;
  assign o_mc_regwrite = i_mc_regwrite;
  assign o_mc_pcplus4  = i_mc_pcplus4;
  assign o_mc_memread  = i_mc_memread;
  assign o_mc_memwrite = i_mc_memwrite;

`ifdef ARVI_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg;
  logic [XLEN-1:0] r_a, r_hi, r_lo, r_result;

  logic [2:0]      w_f3;
  logic            w_neg_a, w_neg_b, w_is_div, w_dz, w_ovf, w_start_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_special;
  logic [XLEN:0]   w_sum, w_rsh, w_diff;
  logic [XLEN-1:0] w_hi_next, w_lo_next, w_qr, w_qr_s, w_final;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic            w_unused;

  assign w_f3     = i_inst[14:12];
  assign w_is_div = w_f3[2];
  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 only for MUL/MULH/DIV/REM
  assign w_neg_a  = i_rs1[XLEN-1] && !(w_f3 == 3'b011 || w_f3[2:0] == 3'b101 || w_f3 == 3'b111);
  assign w_neg_b  = i_rs2[XLEN-1] && (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b100 || w_f3 == 3'b110);
  assign w_mag_a  = w_neg_a ? -i_rs1 : i_rs1;
  assign w_mag_b  = w_neg_b ? -i_rs2 : i_rs2;
  assign w_dz     = (i_rs2 == '0);
  assign w_ovf    = !w_f3[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
  // Remainder takes the dividend's sign; a zero-divisor quotient stays all-ones
  assign w_start_neg = !w_is_div ? (w_neg_a ^ w_neg_b) :
                       w_f3[1]   ? w_neg_a :
                       w_dz      ? 1'b0 : (w_neg_a ^ w_neg_b);
  assign w_special = w_f3[1] ? (w_dz ? i_rs1 : '0)
                             : (w_dz ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_rsh  = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_rsh - {1'b0, r_a};

  always_comb begin
    w_hi_next = w_sum[XLEN:1];
    w_lo_next = {w_sum[0], r_lo[XLEN-1:1]};
    if (r_f3[2]) begin
      if (!w_diff[XLEN]) begin
        w_hi_next = w_diff[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_next = w_rsh[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign w_prod   = {w_hi_next, w_lo_next};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_qr     = r_f3[1] ? w_hi_next : w_lo_next;
  assign w_qr_s   = r_neg ? -w_qr : w_qr;
  assign w_final  = r_f3[2] ? w_qr_s :
                    (r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_m_op) begin
            r_f3  <= w_f3;
            r_neg <= w_start_neg;
            r_cnt <= '0;
            r_hi  <= '0;
            r_a   <= w_is_div ? w_mag_b : w_mag_a;
            r_lo  <= w_is_div ? w_mag_a : w_mag_b;
            if (FAST_SPECIAL && w_is_div && (w_dz || w_ovf)) begin
              r_result <= w_special;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN - 1)) begin
            r_result <= w_final;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!i_hold) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stall = !i_rst && (((r_state == S_IDLE) && w_m_op && !i_flush) || (r_state == S_BUSY));
  assign o_alu_res            = (r_state == S_DONE) ? r_result : w_alu;
  assign o_ex_inst_illegal    = 1'b0;
  assign o_mc_ex_inst_illegal = i_mc_ex_inst_illegal;
  assign w_unused = ^{i_inst[24:15], i_inst[11:7]};
`else
  logic w_unused;

  assign o_alu_res            = w_m_op ? '0 : w_alu;
  assign o_stall              = 1'b0;
  assign o_ex_inst_illegal    = w_m_op;
  assign o_mc_ex_inst_illegal = i_mc_ex_inst_illegal | w_m_op;
  assign w_unused = ^{i_clk, i_rst, i_hold, i_flush, i_inst[24:7], FAST_SPECIAL};
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: ALU vector table, random ALU vs model, M-extension sequences.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, pc, rs1, rs2, imm;
  logic        alusrc, hold, flush;
  logic [3:0]  alu_op;
  logic [5:0]  mc_in;
  logic [31:0] alu_res, pc_jump, wr_data;
  logic        z, stall, illegal;
  logic [5:0]  mc_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .i_clk(clk), .i_rst(rst), .i_inst(inst), .i_pc(pc), .i_rs1(rs1), .i_rs2(rs2),
    .i_imm(imm), .i_alusrc(alusrc), .i_alu_op(alu_op), .i_hold(hold), .i_flush(flush),
    .i_mc_memtoreg(mc_in[0]), .i_mc_regwrite(mc_in[1]), .i_mc_pcplus4(mc_in[2]),
    .i_mc_memread(mc_in[3]), .i_mc_memwrite(mc_in[4]), .i_mc_ex_inst_illegal(mc_in[5]),
    .o_alu_res(alu_res), .o_z(z), .o_pc_jump(pc_jump), .o_wr_data(wr_data),
    .o_stall(stall), .o_ex_inst_illegal(illegal),
    .o_mc_memtoreg(mc_out[0]), .o_mc_regwrite(mc_out[1]), .o_mc_pcplus4(mc_out[2]),
    .o_mc_memread(mc_out[3]), .o_mc_memwrite(mc_out[4]), .o_mc_ex_inst_illegal(mc_out[5])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * (32'd1 << sh);
      4'd3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a / (32'd1 << sh);
      4'd7:  return 32'(int'(a) >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int m_stall_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  task automatic drive_nop(input logic [31:0] a, input logic [31:0] b);
    inst = 32'h0000_0013; rs1 = a; rs2 = b; alusrc = 1'b0; alu_op = 4'd0; mc_in = '0;
  endtask

  task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    inst = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    rs1 = a; rs2 = b; alusrc = 1'b0; alu_op = 4'd0; mc_in = '0;
  endtask

  // Runs one M op from IDLE; checks stall length and the DONE-cycle result
  task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int n;
    @(posedge clk); #1;
    drive_mop(f3, a, b);
    #1;
`ifdef ARVI_MULDIV_EN
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #2;
    end
    chk({name, " stall_cycles"}, n, exp_stall);
    chk({name, " result"}, alu_res, exp);
    chk({name, " stall_done"}, {31'd0, stall}, 32'd0);
    $display("mop %s f3=%0d a=%h b=%h res=%h stall=%0d", name, f3, a, b, alu_res, n);
`else
    chk({name, " illegal"}, {31'd0, illegal}, 32'd1);
    chk({name, " mc_illegal"}, {31'd0, mc_out[5]}, 32'd1);
    chk({name, " result0"}, alu_res, 32'd0);
    chk({name, " stall0"}, {31'd0, stall}, 32'd0);
    $display("mop %s f3=%0d illegal=%0d exp_res_if_enabled=%h stall_if_enabled=%0d", name, f3, illegal, exp, exp_stall);
`endif
    @(posedge clk); #1;
    drive_nop(32'd1, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic        src;
    logic [31:0] exp;
    logic        z;
  } avec_t;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    int          stall;
  } mvec_t;

  avec_t atab[13];
  mvec_t mtab[14];

  initial begin
    logic [31:0] ra, rb, rexp;
    logic [2:0]  rf3;
    int n;

    atab[0]  = '{4'd0, 32'd5, 32'd0, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFE, 1'b0};
    atab[1]  = '{4'd1, 32'd9, 32'd9, 32'd0, 1'b0, 32'd0, 1'b1};
    atab[2]  = '{4'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 32'hF800_0000, 1'b0};
    atab[3]  = '{4'd2, 32'd1, 32'd31, 32'd0, 1'b0, 32'h8000_0000, 1'b0};
    atab[4]  = '{4'd2, 32'd1, 32'd33, 32'd0, 1'b0, 32'd2, 1'b0};
    atab[5]  = '{4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1, 1'b0};
    atab[6]  = '{4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 1'b1};
    atab[7]  = '{4'd5, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd0, 1'b0, 32'h0F0F_F0F0, 1'b0};
    atab[8]  = '{4'd6, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 32'h0800_0000, 1'b0};
    atab[9]  = '{4'd8, 32'h00FF_00FF, 32'h0F00_0F00, 32'd0, 1'b0, 32'h0FFF_0FFF, 1'b0};
    atab[10] = '{4'd9, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 1'b0, 32'h0F00_0F00, 1'b0};
    atab[11] = '{4'd10, 32'd7, 32'd0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
    atab[12] = '{4'd11, 32'd7, 32'd3, 32'd0, 1'b0, 32'd0, 1'b1};

    mtab[0]  = '{"MULH",     3'd1, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 33};
    mtab[1]  = '{"MUL",      3'd0, 32'h8000_0000, 32'd2, 32'd0, 33};
    mtab[2]  = '{"DIV",      3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
    mtab[3]  = '{"REM",      3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
    mtab[4]  = '{"DIVU",     3'd5, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33};
    mtab[5]  = '{"DIVU_DZ",  3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1};
    mtab[6]  = '{"REM_DZ",   3'd6, 32'd100, 32'd0, 32'd100, 1};
    mtab[7]  = '{"DIV_OVF",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    mtab[8]  = '{"REM_OVF",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
    mtab[9]  = '{"MULHU",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    mtab[10] = '{"MULHSU",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    mtab[11] = '{"REMU",     3'd7, 32'd100, 32'd7, 32'd2, 33};
    mtab[12] = '{"DIV_NDZ",  3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1};
    mtab[13] = '{"DIVU_BIG", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};

    // Reset state
    rst = 1'b1; hold = 1'b0; flush = 1'b0; pc = 32'h100; imm = 32'd0;
    drive_nop(32'd3, 32'd4);
    #2;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    chk("reset alu_res", alu_res, 32'd7);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ALU table
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      inst = 32'h0000_0033; alu_op = atab[i].op; rs1 = atab[i].a; rs2 = atab[i].b;
      imm = atab[i].imm; alusrc = atab[i].src; pc = 32'h1000 + 32'(i) * 4; mc_in = 6'(i);
      #1;
      chk($sformatf("alu_tab%0d res", i), alu_res, atab[i].exp);
      chk($sformatf("alu_tab%0d z", i), {31'd0, z}, {31'd0, atab[i].z});
      chk($sformatf("alu_tab%0d stall", i), {31'd0, stall}, 32'd0);
      chk($sformatf("alu_tab%0d pc_jump", i), pc_jump, 32'h1000 + 32'(i) * 4 + atab[i].imm);
      chk($sformatf("alu_tab%0d mc", i), {26'd0, mc_out}, 32'(i));
      $display("alu_tab%0d op=%0d a=%h b=%h res=%h z=%0d", i, atab[i].op, atab[i].a, atab[i].b, alu_res, z);
    end

    // Random ALU against model
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      inst = $urandom; inst[6:0] = 7'b0010011;
      alu_op = 4'($urandom_range(0, 15)); rs1 = $urandom; rs2 = $urandom; imm = $urandom;
      alusrc = 1'($urandom); pc = $urandom; mc_in = 6'($urandom);
      rexp = alu_model(alu_op, rs1, alusrc ? imm : rs2);
      #1;
      chk("rand_alu res", alu_res, rexp);
      chk("rand_alu z", {31'd0, z}, {31'd0, rexp == 32'd0});
      chk("rand_alu wr_data", wr_data, rs2);
      chk("rand_alu pc_jump", pc_jump, pc + imm);
      chk("rand_alu mc", {26'd0, mc_out}, {26'd0, mc_in});
      chk("rand_alu illegal", {31'd0, illegal}, 32'd0);
      $display("rand_alu%0d op=%0d res=%h exp=%h", i, alu_op, alu_res, rexp);
    end

    // M-extension directed table
    @(posedge clk); #1;
    drive_nop(32'd1, 32'd1);
    for (int i = 0; i < 14; i++)
      run_mop(mtab[i].name, mtab[i].f3, mtab[i].a, mtab[i].b, mtab[i].exp, mtab[i].stall);

    // Random M ops against model
    for (int i = 0; i < 20; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_mop("rand_mop", rf3, ra, rb, m_model(rf3, ra, rb), m_stall_model(rf3, ra, rb));
    end

`ifdef ARVI_MULDIV_EN
    // Hold in DONE: result stays, no restart
    @(posedge clk); #1;
    drive_mop(3'd0, 32'd3, 32'd5);
    #1; n = 0;
    while (stall === 1'b1 && n < 100) begin n++; @(posedge clk); #2; end
    chk("hold reach_done", n, 33);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      if (k == 2) hold = 1'b0;
      chk("hold result", alu_res, 32'd15);
      chk("hold stall", {31'd0, stall}, 32'd0);
    end
    @(posedge clk); #1;
    drive_nop(32'd20, 32'd22);
    #1;
    chk("hold exit res", alu_res, 32'd42);
    chk("hold exit stall", {31'd0, stall}, 32'd0);
    $display("hold sequence done res=%h", alu_res);

    // Flush during BUSY cycle 10
    @(posedge clk); #1;
    drive_mop(3'd0, 32'd7, 32'd9);
    for (int k = 0; k < 10; k++) @(posedge clk);
    #2;
    flush = 1'b1;
    chk("flush busy stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    drive_nop(32'd1, 32'd2);
    #1;
    for (int k = 0; k < 30; k++) begin
      chk("flush stall", {31'd0, stall}, 32'd0);
      chk("flush res", alu_res, 32'd3);
      @(posedge clk); #2;
    end
    $display("flush sequence done res=%h", alu_res);

    // Asynchronous reset mid-BUSY
    @(posedge clk); #1;
    drive_mop(3'd0, 32'd7, 32'd9);
    for (int k = 0; k < 6; k++) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid stall", {31'd0, stall}, 32'd0);
    chk("rst_mid res", alu_res, 32'd16);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_nop(32'd1, 32'd1);
    #1;
    chk("rst_after stall", {31'd0, stall}, 32'd0);
    $display("reset sequence done");
    run_mop("MUL_after_rst", 3'd0, 32'd7, 32'd9, 32'd63, 33);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
